// File: rtl/inv_key_sched.sv
// inv_key_sched: walks the AES-128 key schedule backwards, starting from the
// round-10 key and emitting one round key per accepted transfer down to round 0.
module inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_nxt;
  logic [127:0] key_nxt;
  logic [3:0]   idx_nxt;
  logic         done_nxt;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_word, sub_word;
  logic [127:0] prev_key;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = gf_mul(x, x);            // x^2
    t = gf_mul(t, x);            // x^3
    t = gf_mul(gf_mul(t, t), x); // x^7
    t = gf_mul(gf_mul(t, t), x); // x^15
    t = gf_mul(gf_mul(t, t), x); // x^31
    t = gf_mul(gf_mul(t, t), x); // x^63
    t = gf_mul(gf_mul(t, t), x); // x^127
    return gf_mul(t, t);         // x^254
  endfunction

  // Forward AES S-box: field inverse followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Round constant applied when stepping back from round i to i-1
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];

  // Undo the forward recurrence from the top word down; p3 must exist before p0
  assign p3       = w3 ^ w2;
  assign p2       = w2 ^ w1;
  assign p1       = w1 ^ w0;
  assign rot_word = {p3[23:0], p3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_word[8*b +: 8] = sbox(rot_word[8*b +: 8]);
  end

  assign p0       = w0 ^ sub_word ^ {rcon(round_idx), 24'h000000};
  assign prev_key = {p0, p1, p2, p3};

  // A key is on offer for the whole RUN state
  assign busy      = (state == RUN);
  assign key_valid = (state == RUN);

  // Next-state, next-key and done-pulse selection
  always_comb begin
    state_nxt = state;
    key_nxt   = round_key;
    idx_nxt   = round_idx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // The done cycle still belongs to the finished run, so start waits a cycle
        if (start && !done) begin
          key_nxt   = last_key;
          idx_nxt   = 4'(NR);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (key_ready) begin
          if (round_idx == 4'd0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            key_nxt = prev_key;
            idx_nxt = round_idx - 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, key and index registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      round_key <= key_nxt;
      round_idx <= idx_nxt;
      done      <= done_nxt;
    end
  end

endmodule
